slot_arbiter: RTL

SLOT_ARBITER -- requirements
Module: slot_arbiter

---
 rtl/stall_pkg.sv | 20 ++
 rtl/arb_out_fifo.sv | 98 +++++++++
 rtl/slot_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stall_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stall_pkg
//  Description : Shared defaults and helpers for the slot arbiter block.
//                Holds the default requester count and data width, plus the
//                index-width function used to size requester/pointer fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package stall_pkg;

   localparam int c_N_REQ_DEF  = 4;
   localparam int c_DATA_W_DEF = 32;

   // Width needed to hold an index in [0, n-1]; never narrower than 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arb_out_fifo
//  Description : Small synchronous FIFO holding granted words (data + source
//                index) until downstream accepts them. Head word is presented
//                combinationally from storage, so it holds still while no pop
//                occurs.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous active-high reset (clears storage too)
//                flush - synchronous clear of occupancy
//                push  - write din at tail
//                pop   - remove head word
//                din   - word to write
//                dout  - head word
//                count - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_out_fifo
   import stall_pkg::*;
#(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   localparam int                 c_PTR_W    = idx_w(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [CNT_W-1:0]   c_CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
   endfunction

   assign w_full    = (r_count == c_CNT_FULL);
   assign w_empty   = (r_count == '0);
   // A push at full is dropped rather than corrupting the head entry.
   assign w_do_push = push && !w_full;
   assign w_do_pop  = pop && !w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;

   // The arbiter throttles grants so occupancy never exceeds 3; a push at
   // full indicates a broken throttle.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slot_arbiter
//  Description : Round-robin arbiter with burst limit feeding an output FIFO.
//                A grant issued in cycle t opens a data phase in cycle t+1;
//                the granted requester's word (if valid) is queued with its
//                source index. Grants are throttled on FIFO occupancy so the
//                FIFO never overflows even while downstream stalls.
//  Ports       : clk       - clock, rising edge
//                reset     - synchronous active-high reset
//                flush     - synchronous pipeline flush
//                req       - per-requester request
//                in_data   - per-requester word, k at [k*DATA_W +: DATA_W]
//                in_valid  - per-requester data-phase valid
//                stall     - downstream not accepting this cycle
//                grant     - registered one-hot-or-zero grant
//                out_data  - FIFO head word
//                out_valid - FIFO non-empty
//                out_src   - requester index of head word
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_arbiter
   import stall_pkg::*;
#(
   parameter int N_REQ      = c_N_REQ_DEF,
   parameter int DATA_W     = c_DATA_W_DEF,
   parameter int BURST_MAX  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   in_data,
   input  logic [N_REQ-1:0]          in_valid,
   input  logic                      stall,
   output logic [N_REQ-1:0]          grant,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   output logic [idx_w(N_REQ)-1:0]   out_src
);

   localparam int                   c_SRC_W     = idx_w(N_REQ);
   localparam int                   c_BURST_W   = $clog2(BURST_MAX + 1);
   localparam int                   c_CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int                   c_FIFO_W    = DATA_W + c_SRC_W;
   localparam logic [c_SRC_W-1:0]   c_LAST_INIT = c_SRC_W'(N_REQ - 1);
   localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(BURST_MAX);
   localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);
   localparam logic [c_CNT_W:0]     c_CNT_LIMIT = (c_CNT_W + 1)'(1);

   // Arbitration state
   logic [N_REQ-1:0]     r_grant;      // grant presented this cycle
   logic [N_REQ-1:0]     r_grant_d;    // grant of the previous cycle: data phase owner
   logic [c_SRC_W-1:0]   r_last;       // last granted requester
   logic [c_BURST_W-1:0] r_burst;      // consecutive grants held by r_last; 0 = no holder

   // Data phase
   logic                 w_push;
   logic [c_SRC_W-1:0]   w_push_src;
   logic [DATA_W-1:0]    w_push_data;
   logic                 w_pop;

   // FIFO
   logic [c_FIFO_W-1:0]  w_fifo_dout;
   logic [c_CNT_W-1:0]   w_count;
   logic [c_CNT_W:0]     w_cnt_after;
   logic                 w_eligible;

   // Selection
   logic [N_REQ-1:0]     w_last_oh;
   logic                 w_others;
   logic                 w_keep;
   logic                 w_rr_found;
   logic [c_SRC_W-1:0]   w_rr_idx;
   logic                 w_win_valid;
   logic [c_SRC_W-1:0]   w_win_idx;
   logic [N_REQ-1:0]     w_win_oh;

   // ------------------------------------------------------------------------
   // Data phase: only the requester granted last cycle is listened to.
   // r_grant_d is cleared by reset/flush, which drops the word belonging to a
   // grant that was in flight when the pipeline was cleared.
   // ------------------------------------------------------------------------
   always_comb begin
      w_push      = 1'b0;
      w_push_src  = '0;
      w_push_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (r_grant_d[k]) begin
            w_push      = in_valid[k];
            w_push_src  = c_SRC_W'(k);
            w_push_data = in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign out_valid = (w_count != '0);
   assign w_pop     = out_valid && !stall;

   // Occupancy after this cycle's push/pop; a new grant is issued only when
   // this is at most 1, so one grant in flight plus one data phase can land
   // during a stall without exceeding 3 entries.
   assign w_cnt_after = {1'b0, w_count}
                      + {{c_CNT_W{1'b0}}, w_push}
                      - {{c_CNT_W{1'b0}}, w_pop};
   assign w_eligible  = !stall && !flush && (w_cnt_after <= c_CNT_LIMIT);

   // ------------------------------------------------------------------------
   // Selection
   // ------------------------------------------------------------------------
   always_comb begin
      w_last_oh         = '0;
      w_last_oh[r_last] = 1'b1;
   end

   assign w_others = |(req & ~w_last_oh);

   // The holder keeps the grant until it has BURST_MAX consecutive grants
   // while someone else waits; a sole requester is never cut off.
   assign w_keep = (r_burst != '0) && req[r_last] &&
                   ((r_burst < c_BURST_MAX) || !w_others);

   // Search starts one past the last grantee; the index sum is r_last-wide so
   // it wraps naturally (N_REQ is a power of two), and i == N_REQ lands back
   // on r_last itself as the lowest-priority candidate.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!w_rr_found && req[r_last + c_SRC_W'(i)]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = r_last + c_SRC_W'(i);
         end
      end
   end

   assign w_win_valid = w_keep || w_rr_found;
   assign w_win_idx   = w_keep ? r_last : w_rr_idx;

   always_comb begin
      w_win_oh            = '0;
      w_win_oh[w_win_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_grant   <= '0;
         r_grant_d <= '0;
         r_last    <= c_LAST_INIT;
         r_burst   <= '0;
      end else begin
         r_grant_d <= r_grant;
         if (w_eligible && w_win_valid) begin
            r_grant <= w_win_oh;
            r_last  <= w_win_idx;
            if (w_keep) begin
               if (r_burst != c_BURST_MAX) begin
                  r_burst <= r_burst + c_BURST_ONE;
               end
            end else begin
               r_burst <= c_BURST_ONE;
            end
         end else begin
            r_grant <= '0;
            // Throttled cycles do not end a burst, but dropping req does.
            if (!req[r_last]) begin
               r_burst <= '0;
            end
         end
      end
   end

   assign grant = r_grant;

   // ------------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------------
   arb_out_fifo #(
      .WIDTH (c_FIFO_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (c_CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .flush (flush),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({w_push_src, w_push_data}),
      .dout  (w_fifo_dout),
      .count (w_count)
   );

   assign out_data = w_fifo_dout[DATA_W-1:0];
   assign out_src  = w_fifo_dout[c_FIFO_W-1:DATA_W];

endmodule
`default_nettype wire
